// File: rtl/pe8_pkg.sv
// pe8_pkg: shared widths and FSM state type for the 8-line priority encoder.
package pe8_pkg;
    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;
    typedef enum logic {IDLE, HOLD} pe8_state_t;
endpackage

// File: rtl/DECODER3.sv
// DECODER3: 3-to-8 one-hot decoder; code i drives X[i].
module DECODER3 (
    input  logic [2:0] A,
    output logic [7:0] X
);
    assign X = 8'(1) << A;
endmodule

// File: rtl/prio_pick8.sv
// prio_pick8: combinational pick of the first set PEND bit at or above ptr, wrapping 7->0.
module prio_pick8
    import pe8_pkg::*;
(
    input  logic [N_REQ-1:0]  PEND,
    input  logic [CODE_W-1:0] ptr,
    output logic [CODE_W-1:0] sel,
    output logic              any
);
    logic [N_REQ-1:0]  rot;
    logic [CODE_W-1:0] idx;
    // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate the index back.
    assign rot = N_REQ'({PEND, PEND} >> ptr);
    always_comb begin
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (rot[i]) idx = CODE_W'(i);
    end
    assign sel = idx + ptr;
    assign any = |PEND;
endmodule

// File: rtl/priority_encoder8.sv
// priority_encoder8: registered 8-to-3 priority encoder with pending store and valid/ack handshake.
module priority_encoder8
    import pe8_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [N_REQ-1:0]  REQ,
    input  logic              ACK,
    input  logic              CLR,
    output logic [CODE_W-1:0] Y,
    output logic              VALID,
    output logic [N_REQ-1:0]  ONEHOT,
    output logic [N_REQ-1:0]  PEND,
    output logic              OVF
);
    logic [N_REQ-1:0]  reqQ;
    logic [N_REQ-1:0]  edges;
    logic [N_REQ-1:0]  decoded;
    logic [N_REQ-1:0]  retireMask;
    logic [CODE_W-1:0] ptr;
    logic [CODE_W-1:0] pickPtr;
    logic [CODE_W-1:0] pickSel;
    logic              pickAny;
    logic              retire;
    pe8_state_t        state;

    assign edges      = REQ & ~reqQ;
    assign retire     = (state == HOLD) && ACK;
    assign retireMask = retire ? decoded : '0;
    assign pickPtr    = ROUND_ROBIN ? ptr : '0;
    assign ONEHOT     = VALID ? decoded : '0;

    prio_pick8 uPick (
        .PEND (PEND),
        .ptr  (pickPtr),
        .sel  (pickSel),
        .any  (pickAny)
    );

    DECODER3 uDec (
        .A (Y),
        .X (decoded)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            reqQ  <= '0;
            PEND  <= '0;
            OVF   <= 1'b0;
            Y     <= '0;
            VALID <= 1'b0;
            ptr   <= '0;
            state <= IDLE;
        end else begin
            reqQ <= REQ;
            if (CLR) begin
                PEND  <= '0;
                OVF   <= 1'b0;
                VALID <= 1'b0;
                ptr   <= '0;
                state <= IDLE;
            end else begin
                // A new edge on the line being retired re-arms it without counting as overflow.
                PEND <= (PEND & ~retireMask) | edges;
                OVF  <= OVF | (|(edges & PEND & ~retireMask));
                case (state)
                    IDLE: if (pickAny) begin
                        Y     <= pickSel;
                        VALID <= 1'b1;
                        state <= HOLD;
                    end
                    HOLD: if (ACK) begin
                        VALID <= 1'b0;
                        ptr   <= Y + 3'd1;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_priority_encoder8.sv
// tb_priority_encoder8: directed bench for fixed and rotating encoders against a behavioural model.
module tb_priority_encoder8;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       CLR = 1'b0;
    logic       ackF = 1'b0, ackR = 1'b0;
    logic [7:0] reqF = 8'h00, reqR = 8'h00;
    logic [2:0] yF, yR;
    logic       validF, validR, ovfF, ovfR;
    logic [7:0] onehotF, onehotR, pendF, pendR;

    int nAssert = 0;
    int nFail = 0;
    bit checkEn = 1'b0;

    logic [7:0] mPend [2];
    logic [7:0] mReqQ [2];
    logic       mOvf [2];
    logic       mValid [2];
    logic [2:0] mY [2];
    logic [2:0] mPtr [2];

    priority_encoder8 #(.ROUND_ROBIN(1'b0)) dutF (
        .CLK(CLK), .RST_N(RST_N), .REQ(reqF), .ACK(ackF), .CLR(CLR),
        .Y(yF), .VALID(validF), .ONEHOT(onehotF), .PEND(pendF), .OVF(ovfF)
    );

    priority_encoder8 #(.ROUND_ROBIN(1'b1)) dutR (
        .CLK(CLK), .RST_N(RST_N), .REQ(reqR), .ACK(ackR), .CLR(CLR),
        .Y(yR), .VALID(validR), .ONEHOT(onehotR), .PEND(pendR), .OVF(ovfR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        nAssert++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #2;
    endtask

    // Model: pending set, one presented code at a time, search starting at ptr (rotating) or 0 (fixed).
    task automatic modelStep(input int m, input logic [7:0] r, input logic a);
        logic [7:0] old, edges;
        logic       retire;
        int         base;
        old = mPend[m];
        edges = r & ~mReqQ[m];
        mReqQ[m] = r;
        if (CLR) begin
            mPend[m] = 8'h00;
            mOvf[m] = 1'b0;
            mValid[m] = 1'b0;
            mPtr[m] = 3'd0;
            return;
        end
        retire = mValid[m] && a;
        for (int i = 0; i < 8; i++)
            if (edges[i] && old[i] && !(retire && int'(mY[m]) == i)) mOvf[m] = 1'b1;
        if (retire) begin
            mPend[m][mY[m]] = 1'b0;
            mValid[m] = 1'b0;
            mPtr[m] = mY[m] + 3'd1;
        end else if (!mValid[m] && old != 8'h00) begin
            base = (m == 1) ? int'(mPtr[m]) : 0;
            for (int k = 7; k >= 0; k--)
                if (old[(base + k) % 8]) mY[m] = 3'((base + k) % 8);
            mValid[m] = 1'b1;
        end
        mPend[m] = mPend[m] | edges;
    endtask

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int m = 0; m < 2; m++) begin
                mPend[m] = 8'h00;
                mReqQ[m] = 8'h00;
                mOvf[m] = 1'b0;
                mValid[m] = 1'b0;
                mY[m] = 3'd0;
                mPtr[m] = 3'd0;
            end
        end else begin
            modelStep(0, reqF, ackF);
            modelStep(1, reqR, ackR);
        end
    end

    always @(negedge CLK) begin
        if (checkEn && RST_N) begin
            chk("f_valid", 8'(validF), 8'(mValid[0]));
            if (mValid[0]) chk("f_y", 8'(yF), 8'(mY[0]));
            chk("f_onehot", onehotF, mValid[0] ? 8'(1) << mY[0] : 8'h00);
            chk("f_pend", pendF, mPend[0]);
            chk("f_ovf", 8'(ovfF), 8'(mOvf[0]));
            chk("r_valid", 8'(validR), 8'(mValid[1]));
            if (mValid[1]) chk("r_y", 8'(yR), 8'(mY[1]));
            chk("r_onehot", onehotR, mValid[1] ? 8'(1) << mY[1] : 8'h00);
            chk("r_pend", pendR, mPend[1]);
            chk("r_ovf", 8'(ovfR), 8'(mOvf[1]));
        end
    end

    initial begin
        logic [7:0] order [3];
        order[0] = 8'd1; order[1] = 8'd4; order[2] = 8'd7;
        repeat (2) @(posedge CLK);
        #2;
        chk("rst_valid", 8'(validF), 8'h00);
        chk("rst_y", 8'(yF), 8'h00);
        chk("rst_onehot", onehotF, 8'h00);
        chk("rst_pend", pendR, 8'h00);
        chk("rst_ovf", 8'(ovfR), 8'h00);
        RST_N = 1'b1;
        checkEn = 1'b1;

        // Single request on line 5
        reqF = 8'h20; tick;
        chk("single_pend", pendF, 8'h20);
        chk("single_notyet", 8'(validF), 8'h00);
        reqF = 8'h00; tick;
        chk("single_valid", 8'(validF), 8'h01);
        chk("single_y", 8'(yF), 8'h05);
        chk("single_onehot", onehotF, 8'h20);
        ackF = 1'b1; tick; ackF = 1'b0;
        chk("single_ackvalid", 8'(validF), 8'h00);
        chk("single_ackpend", pendF, 8'h00);

        // Fixed priority: 8'h92 retires as 1, 4, 7 with one bubble between
        reqF = 8'h92; tick;
        reqF = 8'h00; tick;
        for (int k = 0; k < 3; k++) begin
            chk("fixed_valid", 8'(validF), 8'h01);
            chk("fixed_order", 8'(yF), order[k]);
            ackF = 1'b1; tick; ackF = 1'b0;
            chk("fixed_bubble", 8'(validF), 8'h00);
            tick;
        end
        chk("fixed_pend_empty", pendF, 8'h00);

        // Overflow on line 2, then same-cycle retire and re-request
        reqF = 8'h04; tick;
        reqF = 8'h00; tick;
        chk("ovf_before", 8'(ovfF), 8'h00);
        reqF = 8'h04; tick;
        chk("ovf_set", 8'(ovfF), 8'h01);
        reqF = 8'h00; tick;
        CLR = 1'b1; tick; CLR = 1'b0;
        chk("clr_ovf", 8'(ovfF), 8'h00);
        reqF = 8'h04; tick;
        reqF = 8'h00; tick;
        chk("rere_y", 8'(yF), 8'h02);
        reqF = 8'h04; ackF = 1'b1; tick;
        reqF = 8'h00; ackF = 1'b0;
        chk("rere_pend", pendF, 8'h04);
        chk("rere_ovf", 8'(ovfF), 8'h00);
        chk("rere_valid", 8'(validF), 8'h00);
        tick;
        chk("rere_again", 8'(yF), 8'h02);
        ackF = 1'b1; tick; ackF = 1'b0;
        tick;

        // Rotating mode: 8'h09 from ptr 0, then line 0 reposted
        reqR = 8'h09; tick;
        reqR = 8'h00; tick;
        chk("rr_first", 8'(yR), 8'h00);
        ackR = 1'b1; tick; ackR = 1'b0;
        reqR = 8'h01; tick;
        reqR = 8'h00;
        chk("rr_second", 8'(yR), 8'h03);
        chk("rr_pend", pendR, 8'h09);
        ackR = 1'b1; tick; ackR = 1'b0;
        tick;
        chk("rr_third", 8'(yR), 8'h00);
        ackR = 1'b1; tick; ackR = 1'b0;
        chk("rr_empty", pendR, 8'h00);

        // Flush while holding with every line pending and overflow set
        reqF = 8'hFF; tick;
        reqF = 8'h00; tick;
        chk("flush_pend", pendF, 8'hFF);
        reqF = 8'hFF; tick;
        chk("flush_ovf", 8'(ovfF), 8'h01);
        reqF = 8'h00; tick;
        reqF = 8'hFF; CLR = 1'b1; tick; CLR = 1'b0;
        chk("flush_valid", 8'(validF), 8'h00);
        chk("flush_pend0", pendF, 8'h00);
        chk("flush_ovf0", 8'(ovfF), 8'h00);
        tick;
        chk("flush_noedge", pendF, 8'h00);
        reqF = 8'h00; tick;

        // Asynchronous reset mid-handshake
        reqF = 8'h10; tick;
        reqF = 8'h00; tick;
        chk("arst_pre", 8'(validF), 8'h01);
        #5 RST_N = 1'b0;
        #1;
        chk("arst_valid", 8'(validF), 8'h00);
        chk("arst_y", 8'(yF), 8'h00);
        chk("arst_onehot", onehotF, 8'h00);
        chk("arst_pend", pendF, 8'h00);
        chk("arst_ovf", 8'(ovfF), 8'h00);
        tick;
        RST_N = 1'b1;
        tick; tick;
        chk("arst_lost", 8'(validF), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
